nf_div_seq: RTL and testbench



---
 rtl/nf_div_seq_pkg.sv | 28 ++
 rtl/nf_div_step.sv | 34 +++
 rtl/nf_div_seq.sv | 186 ++++++++++++++++++
 tb/tb_nf_div_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nf_div_seq_pkg.sv
// Shared definitions for the RV32M divide/remainder sequencer:
// MDU op encodings, divider FSM states and small op-decode helpers.
package nf_div_seq_pkg;

   // funct3[1:0] encodings of the divide-class M-extension ops
   localparam logic [1:0] MDU_DIV  = 2'b00;
   localparam logic [1:0] MDU_DIVU = 2'b01;
   localparam logic [1:0] MDU_REM  = 2'b10;
   localparam logic [1:0] MDU_REMU = 2'b11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_CALC = 2'b01,
      DIV_SIGN = 2'b10,
      DIV_DONE = 2'b11
   } div_state_e;

   // DIV and REM treat their operands as two's complement
   function automatic logic mdu_is_signed(input logic [1:0] op);
      return (op[0] == 1'b0);
   endfunction

   // REM and REMU return the remainder instead of the quotient
   function automatic logic mdu_is_rem(input logic [1:0] op);
      return (op[1] == 1'b1);
   endfunction

endpackage

// File: rtl/nf_div_step.sv
// One radix-2 restoring division step. The partial remainder is kept one
// bit wider than XLEN before the compare so that divisors with the MSB set
// (unsigned ops) never lose the shifted-out bit.
module nf_div_step
   import nf_div_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0]   partial_s;
   logic            fits_s;
   logic [XLEN-1:0] diff_s;

   // Shift {rem,quo} left, trial-subtract the divisor and restore on borrow
   always_comb begin
      partial_s = {rem, quo[XLEN-1]};
      fits_s    = (partial_s >= {1'b0, divisor});
      diff_s    = partial_s[XLEN-1:0] - divisor;
      if (fits_s) begin
         rem_next = diff_s;
         quo_next = {quo[XLEN-2:0], 1'b1};
      end else begin
         rem_next = partial_s[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/nf_div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer. Operands are captured as
// magnitudes at acceptance, XLEN restoring steps run one per clock, and a
// final cycle applies the sign. Divide-by-zero and signed overflow finish
// directly from IDLE.
module nf_div_seq
   import nf_div_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            kill,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] ALL_ZERO = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      state_r, state_n;
   logic [1:0]      op_r, op_n;
   logic            sign_a_r, sign_a_n;
   logic            sign_b_r, sign_b_n;
   logic [XLEN-1:0] divisor_r, divisor_n;
   logic [XLEN-1:0] quo_r, quo_n;
   logic [XLEN-1:0] rem_r, rem_n;
   logic [CW-1:0]   cnt_r, cnt_n;
   logic [XLEN-1:0] result_r, result_n;
   logic            res_valid_r, res_valid_n;

   logic            req_signed_s;
   logic [XLEN-1:0] abs_a_s;
   logic [XLEN-1:0] abs_b_s;
   logic            div_zero_s;
   logic            overflow_s;
   logic [XLEN-1:0] step_rem_s;
   logic [XLEN-1:0] step_quo_s;
   logic [XLEN-1:0] quo_fix_s;
   logic [XLEN-1:0] rem_fix_s;

   nf_div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_r),
      .quo      (quo_r),
      .divisor  (divisor_r),
      .rem_next (step_rem_s),
      .quo_next (step_quo_s)
   );

   // Request-side decode: operand magnitudes and the two shortcut cases
   always_comb begin
      req_signed_s = mdu_is_signed(op);
      abs_a_s      = (req_signed_s && srcA[XLEN-1]) ? (~srcA + {{(XLEN-1){1'b0}}, 1'b1}) : srcA;
      abs_b_s      = (req_signed_s && srcB[XLEN-1]) ? (~srcB + {{(XLEN-1){1'b0}}, 1'b1}) : srcB;
      div_zero_s   = (srcB == ALL_ZERO);
      overflow_s   = req_signed_s && (srcA == MOST_NEG) && (srcB == ALL_ONES);
   end

   // Sign fixup of the finished magnitudes, used in the SIGN cycle
   always_comb begin
      quo_fix_s = (mdu_is_signed(op_r) && (sign_a_r != sign_b_r)) ? (~quo_r + {{(XLEN-1){1'b0}}, 1'b1}) : quo_r;
      rem_fix_s = (mdu_is_signed(op_r) && sign_a_r) ? (~rem_r + {{(XLEN-1){1'b0}}, 1'b1}) : rem_r;
   end

   // Next-state and datapath update; kill overrides every state
   always_comb begin
      state_n     = state_r;
      op_n        = op_r;
      sign_a_n    = sign_a_r;
      sign_b_n    = sign_b_r;
      divisor_n   = divisor_r;
      quo_n       = quo_r;
      rem_n       = rem_r;
      cnt_n       = cnt_r;
      result_n    = result_r;
      res_valid_n = res_valid_r;
      if (kill) begin
         state_n     = DIV_IDLE;
         res_valid_n = 1'b0;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               if (req_valid) begin
                  op_n      = op;
                  sign_a_n  = req_signed_s && srcA[XLEN-1];
                  sign_b_n  = req_signed_s && srcB[XLEN-1];
                  divisor_n = abs_b_s;
                  quo_n     = abs_a_s;
                  rem_n     = ALL_ZERO;
                  cnt_n     = {CW{1'b0}};
                  if (div_zero_s) begin
                     state_n     = DIV_DONE;
                     res_valid_n = 1'b1;
                     result_n    = mdu_is_rem(op) ? srcA : ALL_ONES;
                  end else if (overflow_s) begin
                     state_n     = DIV_DONE;
                     res_valid_n = 1'b1;
                     result_n    = mdu_is_rem(op) ? ALL_ZERO : MOST_NEG;
                  end else begin
                     state_n = DIV_CALC;
                  end
               end else begin
                  state_n = DIV_IDLE;
               end
            end
            DIV_CALC: begin
               rem_n = step_rem_s;
               quo_n = step_quo_s;
               cnt_n = cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  state_n = DIV_SIGN;
               end else begin
                  state_n = DIV_CALC;
               end
            end
            DIV_SIGN: begin
               result_n    = mdu_is_rem(op_r) ? rem_fix_s : quo_fix_s;
               res_valid_n = 1'b1;
               state_n     = DIV_DONE;
            end
            DIV_DONE: begin
               if (res_ready) begin
                  state_n     = DIV_IDLE;
                  res_valid_n = 1'b0;
               end else begin
                  state_n = DIV_DONE;
               end
            end
            default: begin
               state_n     = DIV_IDLE;
               res_valid_n = 1'b0;
            end
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= DIV_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r        <= 2'b00;
         sign_a_r    <= 1'b0;
         sign_b_r    <= 1'b0;
         divisor_r   <= ALL_ZERO;
         quo_r       <= ALL_ZERO;
         rem_r       <= ALL_ZERO;
         cnt_r       <= {CW{1'b0}};
         result_r    <= ALL_ZERO;
         res_valid_r <= 1'b0;
      end else begin
         op_r        <= op_n;
         sign_a_r    <= sign_a_n;
         sign_b_r    <= sign_b_n;
         divisor_r   <= divisor_n;
         quo_r       <= quo_n;
         rem_r       <= rem_n;
         cnt_r       <= cnt_n;
         result_r    <= result_n;
         res_valid_r <= res_valid_n;
      end
   end

   assign req_ready = (state_r == DIV_IDLE) && !kill;
   assign busy      = (state_r != DIV_IDLE);
   assign res_valid = res_valid_r;
   assign result    = result_r;

endmodule

// File: tb/tb_nf_div_seq.sv
// Self-checking bench for nf_div_seq: table-driven ops through a result
// scoreboard, plus hand-written hold, kill and reset sequences.
module tb_nf_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        kill;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] result;
   logic        busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[$];

   nf_div_seq #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .kill      (kill),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .op        (op),
      .srcA      (srcA),
      .srcB      (srcB),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Called right after the acceptance edge; counts edges to res_valid
   task automatic wait_collect(input string name);
      int   lat;
      exp_t e;
      lat = 1;
      while (!res_valid && lat < 60) begin
         tick();
         lat++;
      end
      if (sb_q.size() == 0) begin
         failures++;
         checks++;
         $display("FAIL %s scoreboard_empty", name);
      end else begin
         e = sb_q.pop_front();
         check({name, "_lat"}, 32'(lat), 32'(e.lat));
         check({name, "_res"}, result, e.res);
      end
   endtask

   task automatic release_result(input string name);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({name, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input int el);
      exp_t e;
      e.res = er;
      e.lat = el;
      sb_q.push_back(e);
      op = o; srcA = a; srcB = b; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      srcA = 32'hDEAD_BEEF; srcB = 32'h0000_0000; op = 2'b10;
      wait_collect(name);
      release_result(name);
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (o)
         2'b00:   r = 32'($signed(a) / $signed(b));
         2'b01:   r = a / b;
         2'b10:   r = 32'($signed(a) % $signed(b));
         default: r = a % b;
      endcase
      return r;
   endfunction

   initial begin
      int nres;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      rst = 1'b1; kill = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
      op = 2'b00; srcA = 32'd0; srcB = 32'd0;
      tick(); tick();
      rst = 1'b0;
      check("rst_result", result, 32'd0);
      check("rst_valid", {31'd0, res_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);

      vecs.push_back('{"divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34});
      vecs.push_back('{"remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34});
      vecs.push_back('{"div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34});
      vecs.push_back('{"rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34});
      vecs.push_back('{"rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34});
      vecs.push_back('{"div_x_0", 2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1});
      vecs.push_back('{"divu_x_0", 2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1});
      vecs.push_back('{"remu_x_0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 1});
      vecs.push_back('{"div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
      vecs.push_back('{"rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
      vecs.push_back('{"divu_ovf_ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34});
      vecs.push_back('{"divu_big_div", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34});
      vecs.push_back('{"remu_big_div", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34});
      vecs.push_back('{"div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34});
      vecs.push_back('{"rem_m100_m7", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34});
      vecs.push_back('{"div_minneg_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 34});

      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);
      end

      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom();
         rb = $urandom() >> $urandom_range(0, 28);
         rb = rb | 32'h0000_0002;
         run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb), 34);
      end

      // Hold the result in DONE, then release and overlap a new request
      begin
         exp_t e;
         e.res = 32'd100; e.lat = 34;
         sb_q.push_back(e);
         op = 2'b01; srcA = 32'd1000; srcB = 32'd10; req_valid = 1'b1;
         tick();
         req_valid = 1'b0;
         wait_collect("hold");
         for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_result", result, 32'd100);
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
         end
         e.res = 32'd10; e.lat = 34;
         sb_q.push_back(e);
         res_ready = 1'b1; req_valid = 1'b1; op = 2'b01; srcA = 32'd50; srcB = 32'd5;
         tick();
         res_ready = 1'b0;
         check("release_valid", {31'd0, res_valid}, 32'd0);
         check("release_not_accepted", {31'd0, busy}, 32'd0);
         tick();
         req_valid = 1'b0;
         check("next_accepted", {31'd0, busy}, 32'd1);
         wait_collect("b2b");
         release_result("b2b");
      end

      // Kill at CALC iteration 10 together with a new request
      op = 2'b01; srcA = 32'd100; srcB = 32'd7; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      kill = 1'b1; req_valid = 1'b1;
      #1;
      check("kill_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
      kill = 1'b0; req_valid = 1'b0;
      check("kill_busy", {31'd0, busy}, 32'd0);
      check("kill_valid", {31'd0, res_valid}, 32'd0);
      nres = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (res_valid) nres++;
      end
      check("kill_no_result", 32'(nres), 32'd0);

      // Reset in the middle of CALC
      op = 2'b00; srcA = 32'hFFFF_FFF9; srcB = 32'd2; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_valid", {31'd0, res_valid}, 32'd0);
      check("mrst_result", result, 32'd0);
      check("mrst_req_ready", {31'd0, req_ready}, 32'd1);

      run_op("after_rst", 2'b11, 32'd100, 32'd7, 32'd2, 34);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
